// File: rtl/math_pkg.sv
// Shared constants and types for the sequential borrow look-ahead subtractor.
package math_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/bla_4b.sv
// 4-bit borrow look-ahead subtractor slice: d = a - b - bin, bout = borrow out.
module bla_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       bin_i,
  output logic [3:0] d_o,
  output logic       bout_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // borrow is generated when a=0,b=1 and propagated when a==b
  assign g = ~a_i & b_i;
  assign p = ~(a_i ^ b_i);

  assign c[0] = bin_i;
  assign c[1] = g[0] | (p[0] & bin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bin_i);

  assign d_o    = a_i ^ b_i ^ c[3:0];
  assign bout_o = c[4];

endmodule

// File: rtl/sub_seq.sv
// Sequential unsigned subtractor, one 4-bit slice per cycle, LSB slice first.
// Define SUB_SEQ_OVF_EN to add ovf_o (signed overflow, valid with valid_o).
module sub_seq
  import math_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] d_o,
  output logic          b_o
`ifdef SUB_SEQ_OVF_EN
  ,
  output logic          ovf_o
`endif
);

  // state | meaning
  // IDLE  | ready for a request, outputs held at zero
  // CALC  | one slice per cycle, cnt_q counts remaining slices down to 0
  // DONE  | result presented until ready_i

  localparam int NS = DW / SLICE_W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  if (((DW % SLICE_W) != 0) || (DW < SLICE_W)) begin : g_bad_dw
    $fatal(1, "sub_seq: DW must be a multiple of 4 and at least 4");
  end

  sub_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic          bor_q, bor_d;
  logic [3:0]    s_d;
  logic          s_bout;

  bla_4b u_slice (
    .a_i    (a_q[SLICE_W-1:0]),
    .b_i    (b_q[SLICE_W-1:0]),
    .bin_i  (bor_q),
    .d_o    (s_d),
    .bout_o (s_bout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid_i)        state_d = ST_CALC;
      ST_CALC: if (cnt_q == '0)    state_d = ST_DONE;
      ST_DONE: if (ready_i)        state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // result is masked outside DONE so a partial difference is never visible
  always_comb begin
    ready_o = (state_q == ST_IDLE);
    valid_o = (state_q == ST_DONE);
    d_o     = valid_o ? d_q : '0;
    b_o     = valid_o & bor_q;
  end

  // operands shift right one slice per cycle; result slices enter at the top
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    d_d   = d_q;
    bor_d = bor_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE: if (valid_i) begin
        a_d   = a_i;
        b_d   = b_i;
        d_d   = '0;
        bor_d = 1'b0;
        cnt_d = CW'(NS - 1);
      end
      ST_CALC: begin
        a_d   = a_q >> SLICE_W;
        b_d   = b_q >> SLICE_W;
        d_d   = (d_q >> SLICE_W) | (DW'(s_d) << (DW - SLICE_W));
        bor_d = s_bout;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      bor_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      d_q   <= d_d;
      bor_q <= bor_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SUB_SEQ_OVF_EN
  logic a_sign_q, a_sign_d, b_sign_q, b_sign_d;

  // operand registers are shifted away, so the sign bits are kept aside
  always_comb begin
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    if (state_q == ST_IDLE && valid_i) begin
      a_sign_d = a_i[DW-1];
      b_sign_d = b_i[DW-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
    end
  end

  assign ovf_o = valid_o & (a_sign_q ^ b_sign_q) & (d_q[DW-1] ^ a_sign_q);
`endif

endmodule

// File: tb/tb_sub_seq.sv
// Self-checking bench for sub_seq: DW=8 and DW=16 instances against an arithmetic model.
module tb_sub_seq;

  localparam int N_RAND  = 10000;
  localparam int MAX_CYC = 90000;
  localparam logic [7:0] VA [5] = '{8'h35, 8'h00, 8'h80, 8'h55, 8'hFF};
  localparam logic [7:0] VB [5] = '{8'h12, 8'h01, 8'h01, 8'h55, 8'h00};

  typedef struct {
    logic [15:0] d;
    logic        b;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v8, rdy8_o, val8_o, rdy8_i, bo8_o;
  logic [7:0] a8, b8, d8_o;
  logic        v16, rdy16_o, val16_o, rdy16_i, bo16_o;
  logic [15:0] a16, b16, d16_o;
`ifdef SUB_SEQ_OVF_EN
  logic ovf8_o, ovf16_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sub_seq #(.DW(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v8), .ready_o(rdy8_o),
    .a_i(a8), .b_i(b8), .valid_o(val8_o), .ready_i(rdy8_i),
    .d_o(d8_o), .b_o(bo8_o)
`ifdef SUB_SEQ_OVF_EN
    , .ovf_o(ovf8_o)
`endif
  );

  sub_seq #(.DW(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v16), .ready_o(rdy16_o),
    .a_i(a16), .b_i(b16), .valid_o(val16_o), .ready_i(rdy16_i),
    .d_o(d16_o), .b_o(bo16_o)
`ifdef SUB_SEQ_OVF_EN
    , .ovf_o(ovf16_o)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (val8_o !== 1'b0 || d8_o !== 8'h00 || bo8_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out8: valid=%b d=%h b=%b, want 0 00 0", val8_o, d8_o, bo8_o);
    end
    n_checks++;
    if (val16_o !== 1'b0 || d16_o !== 16'h0 || bo16_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out16: valid=%b d=%h b=%b, want 0 0000 0", val16_o, d16_o, bo16_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rdy8_o !== 1'b1 || rdy16_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: ready8=%b ready16=%b, want 1 1", rdy8_o, rdy16_o);
    end
  endtask

  task automatic test_directed8();
    logic [7:0] a, b, ed;
    logic eb, eo;
    int sd;
    for (int i = 0; i < 9; i++) begin
      if (i < 5) begin
        a = VA[i];
        b = VB[i];
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      ed = a - b;
      eb = (a < b);
      sd = int'($signed(a)) - int'($signed(b));
      eo = (sd > 127) || (sd < -128);
      @(negedge clk);
      a8 = a; b8 = b; v8 = 1'b1; rdy8_i = 1'b0;
      n_checks++;
      if (rdy8_o !== 1'b1) begin
        n_errors++;
        $display("FAIL dir8_ready[%0d]: ready=%b, want 1", i, rdy8_o);
      end
      @(posedge clk);
      @(negedge clk);
      v8 = 1'b0; a8 = ~a; b8 = ~b;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (val8_o !== 1'b0) begin
        n_errors++;
        $display("FAIL dir8_early[%0d]: valid=%b one cycle after accept, want 0", i, val8_o);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (val8_o !== 1'b1 || d8_o !== ed || bo8_o !== eb) begin
        n_errors++;
        $display("FAIL dir8_result[%0d] %h-%h: valid=%b d=%h b=%b, want 1 %h %b",
                 i, a, b, val8_o, d8_o, bo8_o, ed, eb);
      end
`ifdef SUB_SEQ_OVF_EN
      n_checks++;
      if (ovf8_o !== eo) begin
        n_errors++;
        $display("FAIL dir8_ovf[%0d] %h-%h: ovf=%b, want %b", i, a, b, ovf8_o, eo);
      end
`endif
      rdy8_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rdy8_i = 1'b0;
      n_checks++;
      if (val8_o !== 1'b0 || rdy8_o !== 1'b1 || d8_o !== 8'h00) begin
        n_errors++;
        $display("FAIL dir8_release[%0d]: valid=%b ready=%b d=%h, want 0 1 00",
                 i, val8_o, rdy8_o, d8_o);
      end
    end
  endtask

  task automatic test_backpressure8();
    @(negedge clk);
    a8 = 8'hA7; b8 = 8'h3C; v8 = 1'b1; rdy8_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (val8_o !== 1'b1 || d8_o !== 8'h6B || bo8_o !== 1'b0 || rdy8_o !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: valid=%b d=%h b=%b ready=%b, want 1 6b 0 0",
                 k, val8_o, d8_o, bo8_o, rdy8_o);
      end
      v8 = ~v8;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    a8 = 8'h10; b8 = 8'h20; v8 = 1'b1; rdy8_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy8_i = 1'b0;
    n_checks++;
    if (val8_o !== 1'b0 || rdy8_o !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_no_same_cycle_accept: valid=%b ready=%b, want 0 1", val8_o, rdy8_o);
    end
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    n_checks++;
    if (rdy8_o !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_accept_next: ready=%b, want 0", rdy8_o);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (val8_o !== 1'b1 || d8_o !== 8'hF0 || bo8_o !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_second_result: valid=%b d=%h b=%b, want 1 f0 1", val8_o, d8_o, bo8_o);
    end
    rdy8_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy8_i = 1'b0;
  endtask

  task automatic test_reset_mid16();
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0FFF; v16 = 1'b1; rdy16_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (val16_o !== 1'b0 || d16_o !== 16'h0 || bo16_o !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_out: valid=%b d=%h b=%b, want 0 0000 0", val16_o, d16_o, bo16_o);
    end
`ifdef SUB_SEQ_OVF_EN
    n_checks++;
    if (ovf16_o !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_ovf: ovf=%b, want 0", ovf16_o);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    a16 = 16'hBEEF; b16 = 16'h1234; v16 = 1'b1;
    #1;
    n_checks++;
    if (rdy16_o !== 1'b1 || val16_o !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_idle: ready=%b valid=%b, want 1 0", rdy16_o, val16_o);
    end
    @(posedge clk);
    @(negedge clk);
    v16 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (val16_o !== (k == 4)) begin
        n_errors++;
        $display("FAIL midreset_latency[%0d]: valid=%b, want %b", k, val16_o, (k == 4));
      end
    end
    n_checks++;
    if (d16_o !== 16'hACBB || bo16_o !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_fresh: d=%h b=%b, want acbb 0", d16_o, bo16_o);
    end
    rdy16_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy16_i = 1'b0;
  endtask

  task automatic test_random16();
    exp_t q[$];
    exp_t e;
    int accepts = 0;
    int results = 0;
    int cycles = 0;
    int sd;
    logic prev_hold = 1'b0;
    logic [15:0] prev_d = '0;
    logic prev_b = 1'b0;
    logic [15:0] a, b;
    while ((accepts < N_RAND || q.size() != 0) && cycles < MAX_CYC) begin
      @(negedge clk);
      cycles++;
      if (prev_hold) begin
        n_checks++;
        if (val16_o !== 1'b1 || d16_o !== prev_d || bo16_o !== prev_b) begin
          n_errors++;
          $display("FAIL rand_hold @%0d: valid=%b d=%h b=%b, want 1 %h %b",
                   cycles, val16_o, d16_o, bo16_o, prev_d, prev_b);
        end
      end
      a = 16'($urandom);
      b = 16'($urandom);
      a16 = a;
      b16 = b;
      v16 = (accepts < N_RAND) && ($urandom_range(7, 0) != 0);
      rdy16_i = ($urandom_range(3, 0) != 0);
      if (rdy16_o === 1'b1 && v16) begin
        e.d = a - b;
        e.b = (a < b);
        sd = int'($signed(a)) - int'($signed(b));
        e.ovf = (sd > 32767) || (sd < -32768);
        q.push_back(e);
        accepts++;
      end
      if (val16_o === 1'b1 && rdy16_i) begin
        results++;
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL rand_unexpected @%0d: d=%h b=%b with no pending request",
                   cycles, d16_o, bo16_o);
        end else begin
          e = q.pop_front();
          if (d16_o !== e.d || bo16_o !== e.b) begin
            n_errors++;
            $display("FAIL rand_result #%0d: d=%h b=%b, want %h %b",
                     results, d16_o, bo16_o, e.d, e.b);
          end
`ifdef SUB_SEQ_OVF_EN
          n_checks++;
          if (ovf16_o !== e.ovf) begin
            n_errors++;
            $display("FAIL rand_ovf #%0d: ovf=%b, want %b", results, ovf16_o, e.ovf);
          end
`endif
        end
      end
      prev_hold = (val16_o === 1'b1) && !rdy16_i;
      prev_d = d16_o;
      prev_b = bo16_o;
      @(posedge clk);
    end
    @(negedge clk);
    v16 = 1'b0;
    rdy16_i = 1'b0;
    n_checks++;
    if (cycles >= MAX_CYC) begin
      n_errors++;
      $display("FAIL rand_timeout: %0d cycles, %0d accepts, %0d pending", cycles, accepts, q.size());
    end
    n_checks++;
    if (results != accepts || accepts != N_RAND) begin
      n_errors++;
      $display("FAIL rand_count: results=%0d accepts=%0d, want both %0d", results, accepts, N_RAND);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; rdy8_i = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; rdy16_i = 1'b0;
    test_reset();
    test_directed8();
    test_backpressure8();
    test_reset_mid16();
    test_random16();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
